// File: rtl/bus_arbiter.sv
// bus_arbiter: two-master arbiter onto a single shared slave bus.
// Ownership is held for a burst of up to BURST_MAX transfers while the other
// master waits; an owner with no competition is never preempted. Read data
// returns one cycle after acceptance and is steered to the master that issued it.
module bus_arbiter #(
    parameter int WIDTH     = 32,
    parameter int BURST_MAX = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             m0_req,
    input  logic [WIDTH-1:0] m0_addr,
    input  logic [WIDTH-1:0] m0_wdata,
    input  logic [3:0]       m0_be,
    input  logic             m0_we,
    output logic             m0_gnt,
    output logic [WIDTH-1:0] m0_rdata,
    output logic             m0_rvalid,
    input  logic             m1_req,
    input  logic [WIDTH-1:0] m1_addr,
    input  logic [WIDTH-1:0] m1_wdata,
    input  logic [3:0]       m1_be,
    input  logic             m1_we,
    output logic             m1_gnt,
    output logic [WIDTH-1:0] m1_rdata,
    output logic             m1_rvalid,
    output logic [WIDTH-1:0] s_addr,
    output logic [WIDTH-1:0] s_wdata,
    output logic [3:0]       s_be,
    output logic             s_we,
    input  logic [WIDTH-1:0] s_rdata
);

    localparam int CNT_W = $clog2(BURST_MAX + 1);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    state_t           state;
    logic             last_owner;
    logic [CNT_W-1:0] burst_cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             burst_done;
    logic             rd_pending;
    logic             rd_owner;
    logic             gnt0;
    logic             gnt1;
    logic             rd_accept;

    // Saturating increment of the burst counter
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        if (c >= CNT_W'(BURST_MAX)) return CNT_W'(BURST_MAX);
        else                        return c + 1'b1;
    endfunction

    // Grants follow the owner's request in the same cycle; the shared bus is
    // parked at zero whenever no transfer is being accepted
    always_comb begin
        gnt0    = (state == OWN0) && m0_req;
        gnt1    = (state == OWN1) && m1_req;
        s_addr  = '0;
        s_wdata = '0;
        s_be    = '0;
        s_we    = 1'b0;
        if (gnt0) begin
            s_addr  = m0_addr;
            s_wdata = m0_wdata;
            s_be    = m0_be;
            s_we    = m0_we;
        end else if (gnt1) begin
            s_addr  = m1_addr;
            s_wdata = m1_wdata;
            s_be    = m1_be;
            s_we    = m1_we;
        end
        cnt_next   = (gnt0 || gnt1) ? sat_inc(burst_cnt) : burst_cnt;
        burst_done = (cnt_next == CNT_W'(BURST_MAX));
        rd_accept  = (gnt0 && !m0_we) || (gnt1 && !m1_we);
    end

    assign m0_gnt    = gnt0;
    assign m1_gnt    = gnt1;
    assign m0_rdata  = s_rdata;
    assign m1_rdata  = s_rdata;
    assign m0_rvalid = rd_pending && !rd_owner;
    assign m1_rvalid = rd_pending &&  rd_owner;

    // Ownership FSM with burst counting and round-robin tie break
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            last_owner <= 1'b1;
            burst_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    burst_cnt <= '0;
                    if (m0_req && (!m1_req || last_owner)) state <= OWN0;
                    else if (m1_req)                       state <= OWN1;
                end
                OWN0: begin
                    if (m1_req && (!m0_req || burst_done)) begin
                        state      <= OWN1;
                        last_owner <= 1'b0;
                        burst_cnt  <= '0;
                    end else if (!m0_req && !m1_req) begin
                        state      <= IDLE;
                        last_owner <= 1'b0;
                        burst_cnt  <= '0;
                    end else begin
                        burst_cnt  <= cnt_next;
                    end
                end
                OWN1: begin
                    if (m0_req && (!m1_req || burst_done)) begin
                        state      <= OWN0;
                        last_owner <= 1'b1;
                        burst_cnt  <= '0;
                    end else if (!m0_req && !m1_req) begin
                        state      <= IDLE;
                        last_owner <= 1'b1;
                        burst_cnt  <= '0;
                    end else begin
                        burst_cnt  <= cnt_next;
                    end
                end
                default: begin
                    state     <= IDLE;
                    burst_cnt <= '0;
                end
            endcase
        end
    end

    // Remember which master issued the read so its rvalid follows it even
    // across an ownership change
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_pending <= 1'b0;
            rd_owner   <= 1'b0;
        end else begin
            rd_pending <= rd_accept;
            rd_owner   <= gnt1;
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed scenarios plus randomized traffic, checked every
// cycle against a behavioural model of ownership, bursts and read returns.
module tb_bus_arbiter;

    localparam int W  = 32;
    localparam int BM = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          m0_req, m1_req, m0_we, m1_we;
    logic [W-1:0]  m0_addr, m1_addr, m0_wdata, m1_wdata;
    logic [3:0]    m0_be, m1_be;
    logic          m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
    logic [W-1:0]  m0_rdata, m1_rdata;
    logic [W-1:0]  s_addr, s_wdata, s_rdata;
    logic [3:0]    s_be;
    logic          s_we;

    bus_arbiter #(.WIDTH(W), .BURST_MAX(BM)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_be(m0_be),
        .m0_we(m0_we), .m0_gnt(m0_gnt), .m0_rdata(m0_rdata), .m0_rvalid(m0_rvalid),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_be(m1_be),
        .m1_we(m1_we), .m1_gnt(m1_gnt), .m1_rdata(m1_rdata), .m1_rvalid(m1_rvalid),
        .s_addr(s_addr), .s_wdata(s_wdata), .s_be(s_be), .s_we(s_we),
        .s_rdata(s_rdata)
    );

    always #5 clk = ~clk;

    // Simple slave: read data appears one cycle after the address
    logic [W-1:0] ram [16];
    always @(posedge clk) s_rdata <= ram[s_addr[5:2]];

    // Reference model state
    int           own;        // -1 none, 0 master0, 1 master1
    int           last;
    int           cnt;
    bit           pend;
    int           pend_own;
    logic [W-1:0] pend_addr;
    logic [1:0]   hist[$];

    int total = 0;
    int bad   = 0;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chkw(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        own = -1; last = 1; cnt = 0; pend = 0; pend_own = 0; pend_addr = '0;
    endtask

    // One clock cycle: check outputs at the falling edge, advance model at the rising edge
    task automatic step();
        bit g0, g1, rx, ry;
        logic [W-1:0] ea, ed;
        logic [3:0] eb;
        logic ewe;
        @(negedge clk);
        g0 = (own == 0) && m0_req;
        g1 = (own == 1) && m1_req;
        ea = '0; ed = '0; eb = '0; ewe = 1'b0;
        if (g0) begin ea = m0_addr; ed = m0_wdata; eb = m0_be; ewe = m0_we; end
        if (g1) begin ea = m1_addr; ed = m1_wdata; eb = m1_be; ewe = m1_we; end
        hist.push_back({m1_gnt, m0_gnt});
        chk1("m0_gnt", m0_gnt, g0);
        chk1("m1_gnt", m1_gnt, g1);
        chkw("s_addr", s_addr, ea);
        chkw("s_wdata", s_wdata, ed);
        chkw("s_be", {28'b0, s_be}, {28'b0, eb});
        chk1("s_we", s_we, ewe);
        chk1("m0_rvalid", m0_rvalid, pend && pend_own == 0);
        chk1("m1_rvalid", m1_rvalid, pend && pend_own == 1);
        if (pend)
            chkw("rdata", (pend_own == 0) ? m0_rdata : m1_rdata, ram[pend_addr[5:2]]);
        @(posedge clk);
        pend      = (g0 && !m0_we) || (g1 && !m1_we);
        pend_own  = g1 ? 1 : 0;
        pend_addr = g1 ? m1_addr : m0_addr;
        if (own < 0) begin
            cnt = 0;
            if (m0_req && !m1_req)      own = 0;
            else if (m1_req && !m0_req) own = 1;
            else if (m0_req && m1_req)  own = (last == 1) ? 0 : 1;
        end else begin
            rx = (own == 0) ? m0_req : m1_req;
            ry = (own == 0) ? m1_req : m0_req;
            if (g0 || g1) cnt = (cnt + 1 > BM) ? BM : cnt + 1;
            if (ry && (!rx || cnt == BM)) begin
                last = own; own = 1 - own; cnt = 0;
            end else if (!rx && !ry) begin
                last = own; own = -1; cnt = 0;
            end
        end
        #1;
    endtask

    task automatic idle_inputs();
        m0_req = 0; m1_req = 0; m0_we = 0; m1_we = 0;
        m0_addr = '0; m1_addr = '0; m0_wdata = '0; m1_wdata = '0;
        m0_be = '0; m1_be = '0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        model_reset();
        #1;
        chk1("rst_m0_gnt", m0_gnt, 1'b0);
        chk1("rst_m1_gnt", m1_gnt, 1'b0);
        chk1("rst_m0_rvalid", m0_rvalid, 1'b0);
        chk1("rst_m1_rvalid", m1_rvalid, 1'b0);
        chk1("rst_s_we", s_we, 1'b0);
        chkw("rst_s_addr", s_addr, '0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic rand_m0(input bit we);
        m0_addr = $urandom; m0_wdata = $urandom; m0_be = 4'($urandom); m0_we = we;
    endtask

    task automatic rand_m1(input bit we);
        m1_addr = $urandom; m1_wdata = $urandom; m1_be = 4'($urandom); m1_we = we;
    endtask

    initial begin
        int n;
        for (int i = 0; i < 16; i++) ram[i] = 32'hC0DE_0000 + 32'(i * 17);
        idle_inputs();
        rst = 1'b0;
        @(posedge clk);
        #1 do_reset();

        // Single read from m0 at 0x10
        m0_req = 1; m0_addr = 32'h10; m0_we = 0; m0_be = 4'hF;
        step();
        step();
        chk1("first_read_gnt", m0_gnt, 1'b0 | (own == 0 && m0_req));
        m0_req = 0;
        step();
        step();

        // Both request continuously from reset: 4x m0, 4x m1, 4x m0
        do_reset();
        m0_req = 1; m1_req = 1;
        step();
        hist.delete();
        for (int i = 0; i < 12; i++) begin
            rand_m0($urandom_range(0, 1)); rand_m1($urandom_range(0, 1));
            step();
        end
        for (int i = 0; i < 12; i++)
            chkw($sformatf("burst_pattern_%0d", i), {30'b0, hist[i]},
                 ((i / 4) % 2 == 0) ? 32'd1 : 32'd2);
        idle_inputs();
        step(); step(); step();

        // m1 alone: 10 consecutive writes, never preempted
        m1_req = 1;
        rand_m1(1);
        step();
        hist.delete();
        for (int i = 0; i < 10; i++) begin
            rand_m1(1);
            step();
        end
        n = 0;
        foreach (hist[i]) if (hist[i] == 2'b10) n++;
        chkw("m1_solo_grants", 32'(n), 32'd10);
        idle_inputs();
        step(); step();

        // m0 read as 4th burst transfer, then m1 takes over
        do_reset();
        m0_req = 1; m1_req = 1;
        rand_m0(1); rand_m1(1);
        step();
        for (int i = 0; i < 3; i++) begin rand_m0(1); step(); end
        rand_m0(0);
        step();
        chk1("switch_m0_rvalid", m0_rvalid, 1'b1);
        chk1("switch_m1_rvalid", m1_rvalid, 1'b0);
        chk1("switch_m1_gnt", m1_gnt, 1'b1);
        step(); step();
        idle_inputs();
        step(); step();

        // Reset pulse mid-burst with a read outstanding
        m0_req = 1; rand_m0(0);
        step();
        step();
        chk1("pre_rst_rvalid", m0_rvalid, 1'b1);
        #1 do_reset();
        idle_inputs();
        step(); step();
        m0_req = 1; rand_m0(0);
        step(); step();
        idle_inputs();
        step(); step();

        // Randomized traffic with occasional resets
        for (int i = 0; i < 400; i++) begin
            m0_req = ($urandom_range(0, 3) != 0);
            m1_req = ($urandom_range(0, 3) != 0);
            rand_m0($urandom_range(0, 1));
            rand_m1($urandom_range(0, 1));
            if ($urandom_range(0, 99) == 0) do_reset();
            else step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
